// File: rtl/cache_cfg_pkg.sv
// Shared configuration for the reconfigurable cache: geometry, associativity
// mode encoding and the writeback/refill address generator FSM states.
package cache_cfg_pkg;

    localparam int WIDTH      = 32;
    localparam int TAG_W      = 19;
    localparam int INDEX_W    = 12;
    localparam int OFFSET_W   = 4;
    localparam int LINE_BEATS = 4;
    localparam int BEAT_W     = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {
        MODE_DM = 2'b00,
        MODE_2W = 2'b01,
        MODE_4W = 2'b10,
        MODE_8W = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cache_line_addr_gen_if.sv
// Memory-side beat port of the line address generator (valid/ready burst).
interface cache_line_addr_gen_if;
    import cache_cfg_pkg::*;

    logic [WIDTH-1:0] mem_addr;
    logic             mem_valid;
    logic             mem_ready;
    logic             mem_last;

    modport master (
        output mem_addr,
        output mem_valid,
        output mem_last,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_valid,
        input  mem_last,
        output mem_ready
    );

endinterface

// File: rtl/cache_addr_compose.sv
// Inverse of the set decode: rebuilds a line base address from the stored
// tag and index; each extra way moves one bit from index to tag.
module cache_addr_compose
    import cache_cfg_pkg::*;
(
    input  mode_e              i_mode,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [INDEX_W-1:0] i_index,
    output logic [WIDTH-1:0]   o_base
);

    always_comb begin
        o_base = '0;
        case (i_mode)
            MODE_DM: o_base = {i_tag[15:0], i_index[11:0], 4'h0};
            MODE_2W: o_base = {i_tag[16:0], i_index[10:0], 4'h0};
            MODE_4W: o_base = {i_tag[17:0], i_index[9:0],  4'h0};
            MODE_8W: o_base = {i_tag[18:0], i_index[8:0],  4'h0};
            default: o_base = '0;
        endcase
    end

endmodule

// File: rtl/cache_line_addr_gen.sv
// Issues a cache line as a 4-beat word burst for writeback/refill.
// Define CRIT_WORD_FIRST_EN for wrapping, critical-word-first beat order.
module cache_line_addr_gen
    import cache_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [TAG_W-1:0]      i_line_tag,
    input  logic [INDEX_W-1:0]    i_line_index,
    input  logic [OFFSET_W-1:0]   i_start_offset,
    cache_line_addr_gen_if.master mem,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    state_t            r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    logic [BEAT_W-1:0] w_beat_word;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  r_base;
    logic              w_capture;

    cache_addr_compose u_compose (
        .i_mode  (mode_e'(i_mode)),
        .i_tag   (i_line_tag),
        .i_index (i_line_index),
        .o_base  (w_base)
    );

    assign w_capture = (r_state == ST_IDLE) && i_start;

`ifdef CRIT_WORD_FIRST_EN
    logic [BEAT_W-1:0] r_word_ofs;
    logic              w_unused_ofs;

    // Beat counter is added to the requested word so the order wraps mod 4.
    assign w_beat_word  = r_word_ofs + r_beat;
    assign w_unused_ofs = ^i_start_offset[1:0];

    always_ff @(posedge clk) begin
        if (w_capture) r_word_ofs <= i_start_offset[3:2];
    end
`else
    logic w_unused_ofs;

    assign w_beat_word  = r_beat;
    assign w_unused_ofs = ^i_start_offset;
`endif

    // Line base is snapshotted so later input changes cannot disturb a burst.
    always_ff @(posedge clk) begin
        if (w_capture) r_base <= w_base;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        mem.mem_addr  = '0;
        mem.mem_valid = 1'b0;
        mem.mem_last  = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_BURST;
                    w_beat_nxt  = '0;
                end
            end
            ST_BURST: begin
                o_busy        = 1'b1;
                mem.mem_valid = 1'b1;
                mem.mem_addr  = r_base | {{(WIDTH-BEAT_W-2){1'b0}}, w_beat_word, 2'b00};
                mem.mem_last  = (r_beat == LAST_BEAT);
                if (mem.mem_ready) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_addr_gen.sv
// Bench for cache_line_addr_gen: directed table, hand-written corner cases and
// randomized bursts checked against an arithmetic model of the line address.
module tb_cache_line_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [18:0] tag;
    logic [11:0] index;
    logic [3:0]  offset;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_addr_gen_if u_if ();

    cache_line_addr_gen dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (start),
        .i_mode         (mode),
        .i_line_tag     (tag),
        .i_line_index   (index),
        .i_start_offset (offset),
        .mem            (u_if),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [18:0] tag;
        logic [11:0] index;
        logic [3:0]  offset;
        logic [31:0] exp_base;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Line address from the field widths alone: mode m gives a (16+m)-bit tag
    // and a (12-m)-bit index above the 16-byte line offset.
    function automatic logic [31:0] model_base(input int m, input int unsigned t, input int unsigned i);
        longint unsigned tb_bits = 16 + m;
        longint unsigned ib_bits = 12 - m;
        longint unsigned tv = t % (64'd1 << tb_bits);
        longint unsigned iv = i % (64'd1 << ib_bits);
        return 32'((tv * (64'd1 << ib_bits) + iv) * 16);
    endfunction

    function automatic int word_of(input int k, input logic [3:0] ofs);
`ifdef CRIT_WORD_FIRST_EN
        return (int'(ofs) / 4 + k) % 4;
`else
        return k;
`endif
    endfunction

    // One full burst; optional stall on one beat and an ignored start pulse.
    task automatic do_burst(input logic [1:0] m, input logic [18:0] t, input logic [11:0] i,
                            input logic [3:0] o, input logic [31:0] exp_base,
                            input int stall_beat, input int stall_cycles, input bit poke);
        int beat = 0;
        int stalls = 0;
        int cycles = 0;
        int hs = 0;
        @(negedge clk);
        start = 1'b1; mode = m; tag = t; index = i; offset = o;
        u_if.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); tag = 19'($urandom); index = 12'($urandom); offset = 4'($urandom);
        while (beat < 4 && cycles < 60) begin
            chk("valid", 32'(u_if.mem_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_in_burst", 32'(done), 32'd0);
            chk("addr", u_if.mem_addr, exp_base + 32'(word_of(beat, o) * 4));
            chk("last", 32'(u_if.mem_last), 32'(beat == 3));
            start = poke && (cycles == 1);
            if (poke && cycles == 1) tag = ~t;
            if (beat == stall_beat && stalls < stall_cycles) begin
                u_if.mem_ready = 1'b0;
                stalls++;
            end else begin
                u_if.mem_ready = 1'b1;
                beat++;
                hs++;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        u_if.mem_ready = 1'b0;
        if (cycles >= 60) chk("burst_timeout", 32'(cycles), 32'd0);
        chk("handshakes", 32'(hs), 32'd4);
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_in_done", 32'(u_if.mem_valid), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_valid", 32'(u_if.mem_valid), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2'b00, 19'h0ABCD, 12'h123, 4'h0, 32'hABCD1230};
        vecs[1] = '{2'b01, 19'h52345, 12'hFAB, 4'h4, 32'h91A2FAB0};
        vecs[2] = '{2'b11, 19'h7FFFF, 12'h1FF, 4'hC, 32'hFFFFFFF0};
        vecs[3] = '{2'b10, 19'h2AAAA, 12'h3FF, 4'h0, 32'hAAAABFF0};
        vecs[4] = '{2'b00, 19'h70001, 12'hFFF, 4'h8, 32'h0001FFF0};

        reset = 1'b0; start = 1'b0; mode = '0; tag = '0; index = '0; offset = '0;
        u_if.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", u_if.mem_addr, 32'd0);
        chk("rst_valid", 32'(u_if.mem_valid), 32'd0);
        chk("rst_last", 32'(u_if.mem_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        for (int v = 0; v < 5; v++)
            do_burst(vecs[v].mode, vecs[v].tag, vecs[v].index, vecs[v].offset,
                     vecs[v].exp_base, -1, 0, 1'b0);

        // Backpressure on beat 2 and a stray start during the burst.
        do_burst(2'b00, 19'h0ABCD, 12'h123, 4'h8, 32'hABCD1230, 1, 3, 1'b0);
        do_burst(2'b00, 19'h0ABCD, 12'h123, 4'h0, 32'hABCD1230, -1, 0, 1'b1);

        // Reset dropped while the third beat is presented.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; tag = 19'h0ABCD; index = 12'h123; offset = 4'h0;
        u_if.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_addr", u_if.mem_addr, 32'hABCD1230 + 32'(word_of(2, 4'h0) * 4));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(u_if.mem_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b1;
        u_if.mem_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_valid", 32'(u_if.mem_valid), 32'd0);
        do_burst(2'b01, 19'h12345, 12'h7AB, 4'h4, 32'h91A2FAB0, -1, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            logic [1:0]  rm;
            logic [18:0] rt;
            logic [11:0] ri;
            logic [3:0]  ro;
            rm = 2'($urandom);
            rt = 19'($urandom);
            ri = 12'($urandom);
            ro = 4'($urandom);
            do_burst(rm, rt, ri, ro, model_base(int'(rm), int'(rt), int'(ri)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
